// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared states, command layout and SPI mode decode
package spi_slave_pkg;
   typedef enum logic [2:0] {IDLE, CMD, RD_PREP, RD_DATA, WR_DATA} state_t;
   localparam int CMD_W = 16;
   localparam int CMD_RW_BIT = 15;
   localparam int CMD_INC_BIT = 14;
   // returns {cpol, sample_on_leading}
   function automatic logic [1:0] mode_decode(input int mode);
      logic [1:0] m;
      m = 2'(mode);
      return {m[1], ~m[0]};
   endfunction
endpackage

// File: rtl/spi_slave_ram_burst_edge.sv
// spi_edge_sync: synchronises SCLK/CS_N/MOSI and derives sample/shift edges and CS events
module spi_edge_sync
   import spi_slave_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SPI_MODE = 0
) (
   input  logic clk,
   input  logic rst_btn,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic sample_edge,
   output logic shift_edge,
   output logic cs_active,
   output logic cs_assert,
   output logic mosi_s
);
   localparam logic [1:0] MD = mode_decode(SPI_MODE);
   localparam int T = SYNC_STAGES - 1;
   logic [T:0] sclk_q, cs_q, mosi_q;
   logic sclk_d, cs_d, armed, toggled;
   // CS chain resets to "active" and armed stays low until CS is seen high,
   // so a CS held low through reset release never opens a frame
   always_ff @(posedge clk or posedge rst_btn)
      if (rst_btn) begin
         sclk_q <= {SYNC_STAGES{MD[1]}};
         cs_q <= '0;
         mosi_q <= '0;
         sclk_d <= MD[1];
         cs_d <= 1'b0;
         armed <= 1'b0;
      end else begin
         sclk_q <= {sclk_q[T-1:0], sclk};
         cs_q <= {cs_q[T-1:0], cs_n};
         mosi_q <= {mosi_q[T-1:0], mosi};
         sclk_d <= sclk_q[T];
         cs_d <= cs_active;
         armed <= armed | cs_q[T];
      end
   assign toggled = sclk_q[T] != sclk_d;
   assign sample_edge = toggled && ((sclk_q[T] != MD[1]) == MD[0]);
   assign shift_edge = toggled && ((sclk_q[T] != MD[1]) != MD[0]);
   assign cs_active = armed & ~cs_q[T];
   assign cs_assert = cs_active & ~cs_d;
   assign mosi_s = mosi_q[T];
endmodule

// File: rtl/spi_slave_ram_burst.sv
// spi_slave_ram_burst: SPI slave with burst read/write access to an internal RAM
module spi_slave_ram_burst
   import spi_slave_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int SPI_MODE = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_btn,
   input  logic              spi_sclk_in,
   input  logic              spi_cs_n_in,
   input  logic              spi_mosi_in,
   output logic              spi_miso_out,
   output logic              spi_miso_oe,
   output logic              wr_pulse,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] last_wr_data,
   output logic              busy,
   output logic              frame_err
);
   localparam int SH_W = (DATA_W > CMD_W) ? DATA_W : CMD_W;
   localparam logic [5:0] CMD_CNT = 6'(CMD_W);
   localparam logic [5:0] DW_CNT = 6'(DATA_W);
   logic sample_edge, shift_edge, cs_active, cs_assert, mosi_s;
   state_t st, st_n;
   logic [5:0] cnt, cnt_n;
   logic [SH_W-2:0] sh, sh_n;
   logic [SH_W-1:0] word;
   logic [ADDR_W-1:0] addr, addr_n, ra, wr_addr_n;
   logic inc, inc_n, seen, seen_n, re, wr_pulse_n, frame_err_n;
   logic [DATA_W-1:0] shout, shout_n, rd_q, wr_data_n, last_n;
   logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .SPI_MODE(SPI_MODE)) u_sync (
      .clk(clk), .rst_btn(rst_btn), .sclk(spi_sclk_in), .cs_n(spi_cs_n_in),
      .mosi(spi_mosi_in), .sample_edge(sample_edge), .shift_edge(shift_edge),
      .cs_active(cs_active), .cs_assert(cs_assert), .mosi_s(mosi_s)
   );

   always_ff @(posedge clk or posedge rst_btn)
      if (rst_btn) begin
         st <= IDLE;
         cnt <= '0;
         sh <= '0;
         addr <= '0;
         inc <= 1'b0;
         seen <= 1'b0;
         shout <= '0;
         wr_pulse <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         last_wr_data <= '0;
         frame_err <= 1'b0;
      end else begin
         st <= st_n;
         cnt <= cnt_n;
         sh <= sh_n;
         addr <= addr_n;
         inc <= inc_n;
         seen <= seen_n;
         shout <= shout_n;
         wr_pulse <= wr_pulse_n;
         wr_addr <= wr_addr_n;
         wr_data <= wr_data_n;
         last_wr_data <= last_n;
         frame_err <= frame_err_n;
      end

   // word always includes the bit arriving this cycle
   always_comb begin
      word = {sh, mosi_s};
      sh_n = sample_edge ? word[SH_W-2:0] : sh;
      st_n = st;
      cnt_n = cnt;
      addr_n = addr;
      inc_n = inc;
      seen_n = seen;
      shout_n = shout;
      wr_pulse_n = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;
      last_n = last_wr_data;
      frame_err_n = 1'b0;
      re = 1'b0;
      ra = addr;
      case (st)
         IDLE: begin
            st_n = cs_assert ? CMD : IDLE;
            cnt_n = cs_assert ? CMD_CNT : cnt;
         end
         CMD: if (sample_edge) begin
            cnt_n = cnt - 6'd1;
            if (cnt == 6'd1) begin
               addr_n = word[ADDR_W-1:0];
               inc_n = word[CMD_INC_BIT];
               cnt_n = DW_CNT;
               st_n = word[CMD_RW_BIT] ? RD_PREP : WR_DATA;
               re = word[CMD_RW_BIT];
               ra = word[ADDR_W-1:0];
            end
         end
         RD_PREP: begin
            shout_n = rd_q;
            seen_n = 1'b0;
            re = 1'b1;
            ra = addr + ADDR_W'(inc);
            st_n = RD_DATA;
         end
         // shift edges before the word's first sample keep the preloaded MSB
         RD_DATA: if (sample_edge) begin
            cnt_n = cnt - 6'd1;
            seen_n = 1'b1;
            if (cnt == 6'd1) begin
               addr_n = addr + ADDR_W'(inc);
               shout_n = rd_q;
               seen_n = 1'b0;
               re = 1'b1;
               ra = addr + ADDR_W'({inc, 1'b0});
               cnt_n = DW_CNT;
            end
         end else if (shift_edge && seen) shout_n = {shout[DATA_W-2:0], 1'b0};
         WR_DATA: if (sample_edge) begin
            cnt_n = cnt - 6'd1;
            if (cnt == 6'd1) begin
               wr_pulse_n = 1'b1;
               wr_addr_n = addr;
               wr_data_n = word[DATA_W-1:0];
               last_n = word[DATA_W-1:0];
               addr_n = addr + ADDR_W'(inc);
               cnt_n = DW_CNT;
            end
         end
         default: st_n = IDLE;
      endcase
      // a word completed in this same cycle counts as a clean boundary
      if (st != IDLE && !cs_active) begin
         frame_err_n = cnt_n != ((st_n == CMD) ? CMD_CNT : DW_CNT);
         st_n = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_pulse) mem[wr_addr] <= wr_data;
      if (re) rd_q <= mem[ra];
   end

   assign spi_miso_out = (st == RD_DATA) & shout[DATA_W-1];
   assign spi_miso_oe = cs_active;
   assign busy = st != IDLE;
endmodule

// File: tb/tb_spi_slave_ram_burst.sv
// tb_spi_slave_ram_burst: directed and random SPI frames against a word-level memory model
module tb_spi_slave_ram_burst;
   localparam int HP = 60;
   logic clk = 1'b0;
   logic rst_btn;
   logic [2:0] sclk, cs_n, mosi, miso, oe, wrp, busy, ferr;
   logic [7:0] wa [3];
   logic [15:0] wdat [3], lwd [3];
   logic [1:0] mode_of [3] = '{2'd0, 2'd1, 2'd3};
   logic [15:0] model [3][256];
   logic [15:0] wbuf [3];
   logic [31:0] wq [$];
   int ferr_cnt [3] = '{0, 0, 0};
   int busy_cnt [3] = '{0, 0, 0};
   int checks = 0, passes = 0, fails = 0;

   always #5 clk = ~clk;

   spi_slave_ram_burst #(.SPI_MODE(0)) u_m0 (
      .clk(clk), .rst_btn(rst_btn), .spi_sclk_in(sclk[0]), .spi_cs_n_in(cs_n[0]),
      .spi_mosi_in(mosi[0]), .spi_miso_out(miso[0]), .spi_miso_oe(oe[0]),
      .wr_pulse(wrp[0]), .wr_addr(wa[0]), .wr_data(wdat[0]), .last_wr_data(lwd[0]),
      .busy(busy[0]), .frame_err(ferr[0]));
   spi_slave_ram_burst #(.SPI_MODE(1)) u_m1 (
      .clk(clk), .rst_btn(rst_btn), .spi_sclk_in(sclk[1]), .spi_cs_n_in(cs_n[1]),
      .spi_mosi_in(mosi[1]), .spi_miso_out(miso[1]), .spi_miso_oe(oe[1]),
      .wr_pulse(wrp[1]), .wr_addr(wa[1]), .wr_data(wdat[1]), .last_wr_data(lwd[1]),
      .busy(busy[1]), .frame_err(ferr[1]));
   spi_slave_ram_burst #(.SPI_MODE(3)) u_m3 (
      .clk(clk), .rst_btn(rst_btn), .spi_sclk_in(sclk[2]), .spi_cs_n_in(cs_n[2]),
      .spi_mosi_in(mosi[2]), .spi_miso_out(miso[2]), .spi_miso_oe(oe[2]),
      .wr_pulse(wrp[2]), .wr_addr(wa[2]), .wr_data(wdat[2]), .last_wr_data(lwd[2]),
      .busy(busy[2]), .frame_err(ferr[2]));

   always @(negedge clk)
      for (int k = 0; k < 3; k++) begin
         if (wrp[k]) wq.push_back({8'(k), wa[k], wdat[k]});
         if (ferr[k]) ferr_cnt[k]++;
         if (busy[k]) busy_cnt[k]++;
      end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // bit-level SPI master; tx/rx hold nb bits MSB first in their low bits
   task automatic xfer(input int k, input int nb, input logic [63:0] tx,
                       output logic [63:0] rx, input bit start_cs, input bit end_cs);
      logic cpol, cpha;
      cpol = mode_of[k][1];
      cpha = mode_of[k][0];
      rx = '0;
      @(negedge clk);
      if (start_cs) begin
         cs_n[k] = 1'b0;
         #(HP);
         check("oe_active", 64'(oe[k]), 64'd1);
      end
      for (int i = nb - 1; i >= 0; i--)
         if (!cpha) begin
            mosi[k] = tx[i];
            #(HP);
            sclk[k] = ~cpol;
            rx = {rx[62:0], miso[k]};
            #(HP);
            sclk[k] = cpol;
         end else begin
            sclk[k] = ~cpol;
            mosi[k] = tx[i];
            #(HP);
            sclk[k] = cpol;
            rx = {rx[62:0], miso[k]};
            #(HP);
         end
      if (end_cs) begin
         #(HP);
         cs_n[k] = 1'b1;
         #(4 * HP);
         check("oe_idle", 64'(oe[k]), 64'd0);
         check("busy_idle", 64'(busy[k]), 64'd0);
      end
   endtask

   task automatic do_write(input int k, input int a, input bit inc, input int n);
      logic [63:0] tx, rx;
      int na;
      tx = 64'({1'b0, inc, 6'b0, 8'(a)});
      for (int i = 0; i < n; i++) tx = (tx << 16) | 64'(wbuf[i]);
      wq.delete();
      xfer(k, 16 + 16 * n, tx, rx, 1'b1, 1'b1);
      check("wr_count", 64'(wq.size()), 64'(n));
      na = a;
      for (int i = 0; i < n; i++) begin
         model[k][na] = wbuf[i];
         if (i < wq.size()) begin
            check("wr_addr", 64'(wq[i][31:16]), 64'({8'(k), 8'(na)}));
            check("wr_data", 64'(wq[i][15:0]), 64'(wbuf[i]));
         end
         na = (na + int'(inc)) % 256;
      end
      check("last_wr_data", 64'(lwd[k]), 64'(wbuf[n-1]));
   endtask

   task automatic do_read(input int k, input int a, input bit inc, input int n);
      logic [63:0] tx, rx;
      int na;
      tx = 64'({1'b1, inc, 6'b0, 8'(a)}) << (16 * n);
      xfer(k, 16 + 16 * n, tx, rx, 1'b1, 1'b1);
      na = a;
      for (int i = 0; i < n; i++) begin
         check("rd_data", 64'(rx[16*(n-1-i) +: 16]), 64'(model[k][na]));
         na = (na + int'(inc)) % 256;
      end
   endtask

   initial begin
      logic [63:0] rx;
      int f0, b0;
      rst_btn = 1'b1;
      cs_n = 3'b111;
      mosi = 3'b000;
      for (int k = 0; k < 3; k++) sclk[k] = mode_of[k][1];
      repeat (4) @(negedge clk);
      for (int k = 0; k < 3; k++)
         check("reset_outputs", 64'({miso[k], oe[k], wrp[k], busy[k], ferr[k], wa[k], wdat[k], lwd[k]}), 64'd0);
      rst_btn = 1'b0;
      repeat (5) @(negedge clk);

      wbuf[0] = 16'hA5C3;
      do_write(0, 8'h05, 1'b0, 1);
      do_read(0, 8'h05, 1'b0, 1);

      wbuf[0] = 16'd1; wbuf[1] = 16'd2; wbuf[2] = 16'd3;
      do_write(0, 8'hFE, 1'b1, 3);
      do_read(0, 8'hFE, 1'b1, 3);

      wbuf[0] = 16'h8001;
      do_write(2, 8'h10, 1'b0, 1);
      do_read(2, 8'h10, 1'b0, 1);
      do_write(1, 8'h10, 1'b0, 1);
      do_read(1, 8'h10, 1'b0, 1);

      wbuf[0] = 16'h1234;
      do_write(0, 8'h20, 1'b0, 1);
      do_read(0, 8'h20, 1'b0, 3);

      // abort after 7 data bits
      wbuf[0] = 16'hBEEF;
      do_write(0, 8'h30, 1'b0, 1);
      f0 = ferr_cnt[0];
      wq.delete();
      xfer(0, 23, 64'({16'h0030, 7'b1010101}), rx, 1'b1, 1'b1);
      check("abort_frame_err", 64'(ferr_cnt[0] - f0), 64'd1);
      check("abort_no_write", 64'(wq.size()), 64'd0);
      do_read(0, 8'h30, 1'b0, 1);
      wbuf[0] = 16'h1357;
      do_write(0, 8'h30, 1'b0, 1);
      do_read(0, 8'h30, 1'b0, 1);

      for (int it = 0; it < 8; it++) begin
         int k, a, n;
         bit inc;
         k = $urandom_range(0, 2);
         a = $urandom_range(0, 255);
         inc = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 3);
         for (int i = 0; i < 3; i++) wbuf[i] = 16'($urandom);
         do_write(k, a, inc, n);
         do_read(k, a, inc, n);
      end

      // reset in the middle of a read, CS then held low through release
      xfer(0, 21, 64'({16'h8005, 5'b0}), rx, 1'b1, 1'b0);
      rst_btn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset_midframe", 64'({miso[0], oe[0], wrp[0], busy[0], ferr[0], wa[0], wdat[0], lwd[0]}), 64'd0);
      rst_btn = 1'b0;
      b0 = busy_cnt[0];
      f0 = ferr_cnt[0];
      wq.delete();
      xfer(0, 32, 64'({16'h0040, 16'h5555}), rx, 1'b0, 1'b0);
      check("held_cs_no_busy", 64'(busy_cnt[0] - b0), 64'd0);
      check("held_cs_no_write", 64'(wq.size()), 64'd0);
      check("held_cs_no_err", 64'(ferr_cnt[0] - f0), 64'd0);
      check("held_cs_oe", 64'(oe[0]), 64'd0);
      cs_n[0] = 1'b1;
      #(4 * HP);
      wbuf[0] = 16'h6789;
      do_write(0, 8'h40, 1'b0, 1);
      do_read(0, 8'h40, 1'b0, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
